// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with row
// synchronizer, press/release debounce and registered key output.
// Ports: clk, reset (async, active-high), rows[3:0] (active-low,
// async), cols[3:0] (one-hot-low drive), key_code[3:0], key_valid
// (one-cycle pulse), key_held.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4800,
  parameter int unsigned DEBOUNCE_CYCLES = 960000,
  parameter int unsigned REPEAT_DELAY    = 24000000,
  parameter int unsigned REPEAT_CYCLES   = 4800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned M0 =
    (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned M1 =
    (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned MAXP = (M0 > M1) ? M0 : M1;
  localparam int unsigned CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_N     = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync_q, rs_q;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;

  logic [CW-1:0] div_inc, cnt_inc;
  logic [1:0]  low_row;
  logic        row_hi;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] RD_N = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RC_N = CW'(REPEAT_CYCLES);
  logic [CW-1:0] rep_q, rep_d, rep_inc;
  logic          first_q, first_d;
  assign rep_inc = (rep_q == '1) ? rep_q : rep_q + CW'(1);
`endif

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    unique case ({r, c})
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'hE;
      4'd13: k = 4'h0;
      4'd14: k = 4'hF;
      4'd15: k = 4'hD;
    endcase
    return k;
  endfunction

  // Counters saturate instead of wrapping.
  assign div_inc = (div_q == '1) ? div_q : div_q + CW'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign row_hi  = rs_q[row_q];

  // Lowest-index low row wins within a column.
  always_comb begin
    low_row = 2'd3;
    if (!rs_q[2]) low_row = 2'd2;
    if (!rs_q[1]) low_row = 2'd1;
    if (!rs_q[0]) low_row = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    first_d = first_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs_q != 4'hF) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_inc;
        end
      end
      DEBOUNCE: begin
        if (row_hi) begin
          col_d   = col_q + 2'd1;
          div_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_N) begin
            code_d  = key_map(row_q, col_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
            first_d = 1'b1;
`endif
          end
        end
      end
      HELD: begin
        if (row_hi) begin
          cnt_d   = '0;
          state_d = RELEASE;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
`ifdef KEYPAD_REPEAT_EN
          rep_d = rep_inc;
          if (rep_inc == (first_q ? RD_N : RC_N)) begin
            valid_d = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end
`endif
        end
      end
      RELEASE: begin
        if (!row_hi) begin
          state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_N) begin
            held_d  = 1'b0;
            col_d   = col_q + 2'd1;
            div_d   = '0;
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 4'hF;
      rs_q    <= 4'hF;
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= rows;
      rs_q    <= sync_q;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end
`endif

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed keypad stimulus checked
// cycle by cycle against a behavioural scanner model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 16;
  localparam int RD = 40;
  localparam int RC = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int A_PULSES = 6;
`else
  localparam int A_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = 4'hF;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // key index = row*4 + col
  logic [3:0] keymap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Behavioural model: phase 0 scan, 1 debounce, 2 held, 3 release
  int         m_ph, m_col, m_row, m_tick, m_cnt, m_since, m_gap;
  logic [3:0] m_code, m_s1, m_rs;
  bit         m_valid, m_held;

  logic [15:0] pressed = '0;
  int          pulses = 0;

  task automatic model_reset();
    m_ph = 0; m_col = 0; m_row = 0; m_tick = 0; m_cnt = 0;
    m_since = 0; m_gap = RD;
    m_code = 4'h0; m_valid = 0; m_held = 0;
    m_s1 = 4'hF; m_rs = 4'hF;
  endtask

  task automatic model_step(input logic [3:0] raw);
    bit hi;
    m_valid = 0;
    hi = m_rs[m_row];
    case (m_ph)
      0: begin
        if (m_tick == SD - 1) begin
          m_tick = 0;
          if (m_rs != 4'hF) begin
            for (int r = 3; r >= 0; r--)
              if (!m_rs[r]) m_row = r;
            m_ph = 1;
            m_cnt = 0;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else begin
          m_tick++;
        end
      end
      1: begin
        if (hi) begin
          m_ph = 0; m_col = (m_col + 1) % 4; m_tick = 0;
        end else begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_code = keymap[m_row*4 + m_col];
            m_valid = 1; m_held = 1; m_ph = 2;
            m_since = 0; m_gap = RD;
          end
        end
      end
      2: begin
        if (hi) begin
          m_ph = 3; m_cnt = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          m_since++;
          if (m_since == m_gap) begin
            m_valid = 1; m_since = 0; m_gap = RC;
          end
`endif
        end
      end
      default: begin
        if (!hi) begin
          m_ph = 2; m_since = 0; m_gap = RD;
        end else begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_held = 0; m_ph = 0;
            m_col = (m_col + 1) % 4; m_tick = 0;
          end
        end
      end
    endcase
    m_rs = m_s1;
    m_s1 = raw;
  endtask

  // Physical keypad: a pressed key pulls its row low when its column is driven.
  function automatic logic [3:0] pad(input logic [3:0] c, input logic [15:0] p);
    logic [3:0] res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (p[r*4 + k] && !c[k]) res[r] = 1'b0;
    return res;
  endfunction

  task automatic set_keys(input logic [15:0] p);
    pressed = p;
    rows = pad(cols, pressed);
  endtask

  task automatic tick();
    logic [3:0] ecols;
    @(posedge clk);
    if (!reset) model_step(rows);
    #1;
    ecols = ~(4'b0001 << m_col);
    check("cols", int'(cols), int'(ecols));
    check("key_code", int'(key_code), int'(m_code));
    check("key_valid", int'(key_valid), int'(m_valid));
    check("key_held", int'(key_held), int'(m_held));
    if (key_valid) pulses++;
    rows = pad(cols, pressed);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_cols", int'(cols), 4'hE);
    check("rst_code", int'(key_code), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_held(input string tag, input bit lvl);
    int k = 0;
    while (key_held != lvl && k < 300) begin
      tick();
      k++;
    end
    check(tag, int'(key_held), int'(lvl));
  endtask

  initial begin
    int p0, k, n, dur;
    logic [15:0] m;
    model_reset();
    #2;
    apply_reset();

    // reset mid-debounce, then idle scan
    set_keys(16'h0020);
    k = 0;
    while (m_ph != 1 && k < 60) begin tick(); k++; end
    check("reach_debounce", int'(k < 60), 1);
    tick(); tick(); tick();
    p0 = pulses;
    apply_reset();
    set_keys(16'h0000);
    for (int i = 0; i < 32; i++) tick();
    check("rst_deb_no_pulse", pulses - p0, 0);

    // clean press of '6'
    p0 = pulses;
    set_keys(16'h0040);
    wait_held("press6_held", 1'b1);
    check("press6_pulses", pulses - p0, 1);
    check("press6_code", int'(key_code), 4'h6);
    check("press6_cols", int'(cols), 4'b1011);
    for (int i = 0; i < 10; i++) tick();
    check("press6_single", pulses - p0, 1);

    // release '6'
    set_keys(16'h0000);
    wait_held("rel6_held", 1'b0);
    check("rel6_cols", int'(cols), 4'b0111);
    check("rel6_code", int'(key_code), 4'h6);

    // bounce during debounce of '*'
    set_keys(16'h1000);
    k = 0;
    while (!(m_ph == 1 && m_cnt == 10) && k < 100) begin tick(); k++; end
    check("star_reach_cnt10", int'(k < 100), 1);
    p0 = pulses;
    set_keys(16'h0000);
    tick(); tick();
    set_keys(16'h1000);
    k = 0;
    while (m_ph != 0 && k < 10) begin tick(); k++; end
    check("bounce_no_pulse", pulses - p0, 0);
    wait_held("star_held", 1'b1);
    check("star_pulses", pulses - p0, 1);
    check("star_code", int'(key_code), 4'hE);
    set_keys(16'h0000);
    wait_held("star_rel", 1'b0);

    // '2' and '8' together, same column
    set_keys(16'h0202);
    wait_held("two_held", 1'b1);
    check("two_code_first", int'(key_code), 4'h2);
    p0 = pulses;
    set_keys(16'h0200);
    k = 0;
    while (pulses == p0 && k < 300) begin tick(); k++; end
    check("two_second_pulse", pulses - p0, 1);
    check("two_code_second", int'(key_code), 4'h8);
    set_keys(16'h0000);
    wait_held("two_rel", 1'b0);

    // hold 'A' for 120 cycles after acceptance
    p0 = pulses;
    set_keys(16'h0008);
    wait_held("a_held", 1'b1);
    for (int i = 0; i < 120; i++) tick();
    check("a_pulses", pulses - p0, A_PULSES);
    check("a_code", int'(key_code), 4'hA);
    set_keys(16'h0000);
    wait_held("a_rel", 1'b0);

    // reset during HELD on '9'
    set_keys(16'h0400);
    wait_held("nine_held", 1'b1);
    tick(); tick();
    apply_reset();
    set_keys(16'h0000);
    for (int i = 0; i < 8; i++) tick();

    // randomized key activity
    for (int e = 0; e < 40; e++) begin
      m = '0;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) m[$urandom_range(0, 15)] = 1'b1;
      set_keys(m);
      dur = $urandom_range(1, 60);
      for (int i = 0; i < dur; i++) tick();
      if ($urandom_range(0, 3) == 0) begin
        set_keys(16'h0000);
        dur = $urandom_range(1, 40);
        for (int i = 0; i < dur; i++) tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the columns of a 4x4 matrix keypad one at a time and reads the rows back.
- This is time-multiplexed input scanning, the inverse of the dual 7-segment output multiplexing.
- Synchronizes and debounces the row inputs, then emits one registered 4-bit key code and a single-cycle valid pulse per debounced press.
- Feeds user key entry into the display and control path of the transcriber.

Parameters:
- SCAN_DIV, 4800, clk cycles each column is driven before advancing; must be >= 4.
- DEBOUNCE_CYCLES, 960000, consecutive stable cycles required to accept a press or a release; must be >= 2.
- REPEAT_DELAY, 24000000, cycles from accepted press to first auto-repeat (used only with the optional feature).
- REPEAT_CYCLES, 4800000, cycles between subsequent auto-repeats (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rows  input  4  keypad rows; active-low, externally pulled up, asynchronous
- cols  output  4  keypad column drive; active-low, one-hot-low
- key_code  output  4  code of the last accepted key, registered
- key_valid  output  1  one-cycle pulse when key_code updates
- key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset values: cols=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Reset mid-operation aborts immediately; no key_valid is emitted.
- Input path: rows pass through a 2-flop synchronizer. All decisions use the synchronized value rs; raw-to-rs latency is 2 cycles.
- Key map as [row][col], codes in hex:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- States:
  - SCAN:
    - cols rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after SCAN_DIV cycles.
    - On the last cycle of a dwell, if any rs bit is 0, lock the current column and the lowest-index low row, go to DEBOUNCE, and reset the counter. cols freezes.
    - Otherwise advance the column.
  - DEBOUNCE:
    - Counter increments each cycle the locked row reads 0.
    - If the locked row reads 1, return to SCAN at the next column. No output change.
    - When the counter reaches DEBOUNCE_CYCLES: key_code <= map[row][col], key_valid=1 for exactly that cycle, key_held <= 1, go to HELD.
  - HELD:
    - cols stays frozen on the locked column.
    - Other keys are ignored, including additional rows in the same column.
    - When the locked row reads 1, reset the counter and go to RELEASE.
  - RELEASE:
    - Counter increments each cycle the locked row reads 1.
    - If it reads 0, return to HELD with no new key_valid (bounce).
    - When the counter reaches DEBOUNCE_CYCLES: key_held <= 0, go to SCAN at the next column.
- key_code holds its value after release until the next accepted press.
- Simultaneous presses: whichever key is found first by the scan wins. Within one column, the lower row index wins.
- A second key pressed while HELD is accepted only after the first key's release completes and the scan reaches it.
- Counters are sized as $clog2 of the largest parameter + 1 and saturate; they never wrap.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at the accepted press.
  - key_valid re-pulses with the same key_code after REPEAT_DELAY cycles, then every REPEAT_CYCLES.
  - Leaving HELD (entering RELEASE) clears the repeat counter; returning from a release bounce restarts it from REPEAT_DELAY.
- Undefined: no repeat logic is generated and exactly one key_valid is emitted per press; REPEAT_* parameters are ignored.

Test Plan:
- All benches run with SCAN_DIV=4, DEBOUNCE_CYCLES=16, REPEAT_DELAY=40, REPEAT_CYCLES=20.
- Reset mid-DEBOUNCE:
  - Stimulus: assert reset, release it, hold rows=4'b1111 for 32 cycles.
  - Required response: cols cycles 1110, 1101, 1011, 0111 in 4-cycle steps; key_valid never asserts.
- Clean press of '6':
  - Stimulus: hold rows[1]=0 whenever cols=1011 (r1,c2).
  - Required response: cols freezes at 1011; exactly one key_valid pulse with key_code=4'h6 after 16 stable cycles; key_held=1.
- Release after '6':
  - Stimulus: release the key for 16 cycles.
  - Required response: key_held=0, cols resumes at 0111, key_code stays 4'h6.
- Bounce during debounce:
  - Stimulus: press '*' (r3,c0) with rows[3] going high at count 10, then held stable.
  - Required response: return to SCAN with no pulse; on the next pass, one pulse with key_code=4'hE.
- Two keys, same column:
  - Stimulus: press '2' and '8' together (c1, rows 0 and 2 low).
  - Required response: key_code=4'h2. Release '2' while '8' is still held: after the release debounce completes, scanning finds '8' and pulses key_code=4'h8.
- Auto-repeat (KEYPAD_REPEAT_EN defined):
  - Stimulus: hold 'A' for 120 cycles after acceptance.
  - Required response: key_valid pulses with key_code=4'hA at accept, +40, +60, +80, +100, +120.
  - Same stimulus with the macro undefined: exactly one pulse.
- Reset during HELD:
  - Stimulus: assert reset while in HELD.
  - Required response: key_held=0, key_code=0, cols=1110 on the same edge; no key_valid pulse.
